// File: rtl/vip_pkg.sv
// vip_pkg: shared FSM, bank types and helpers for the VIP
// 3x3 window line-buffer sequencing path.
package vip_pkg;

   localparam int NUM_BANKS = 3;

   typedef enum logic [1:0] {
      IDLE,
      FRAME,
      LINE
   } state_t;

   typedef logic [1:0] bank_t;

   function automatic bank_t next_bank(input bank_t b);
      return (b >= bank_t'(NUM_BANKS - 1)) ? bank_t'(0) : b + bank_t'(1);
   endfunction

endpackage

// File: rtl/vip_sync_edge.sv
// vip_sync_edge: registers one frame-sync input and emits
// single-cycle rise/fall pulses against the registered copy.
module vip_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic d_q;
   logic armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q   <= 1'b0;
         armed <= 1'b0;
      end else begin
         d_q   <= d;
         armed <= 1'b1;
      end
   end

   // No edge until one real sample exists, so a level held across reset is not an edge
   assign rise = armed & d & ~d_q;
   assign fall = armed & ~d & d_q;

endmodule

// File: rtl/vip_linebuf_ctrl.sv
// vip_linebuf_ctrl: 3x3 window line-buffer sequencer (addresses, bank
// enables, read selects, window valid). Width check: VIP_LINEBUF_WIDTH_CHECK_EN.
module vip_linebuf_ctrl
   import vip_pkg::*;
#(
   parameter int IMG_W_MAX = 1024,
   parameter int ADDR_W    = 10,
   parameter int ROW_W     = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pre_frame_vsync,
   input  logic              pre_frame_href,
   input  logic              pre_frame_clken,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [2:0]        ram_wr_en,
   output logic [1:0]        row1_sel,
   output logic [1:0]        row2_sel,
   output logic [ADDR_W-1:0] col_cnt,
   output logic [ROW_W-1:0]  row_cnt,
   output logic              win_valid,
   output logic              frame_done,
   output logic              err_ovf,
   output logic              err_width
);

   localparam logic [ADDR_W:0]  COL_MAX = (ADDR_W+1)'(IMG_W_MAX);
   localparam logic [ADDR_W:0]  COL_TWO = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0]  COL_ONE = (ADDR_W+1)'(1);
   localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);
   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

   state_t            state_q;
   state_t            state_d;
   bank_t             bank_q;
   logic [ADDR_W:0]   col_q;
   logic [ROW_W-1:0]  row_q;
   logic              vs_rise;
   logic              vs_fall;
   logic              hr_fall;
   logic              hr_rise_unused;
   logic              pix;
   logic              wr_ok;
   logic              win_ok;
   logic              line_end;
   logic              win_d1;

   vip_sync_edge u_vs (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pre_frame_vsync),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   vip_sync_edge u_hr (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pre_frame_href),
      .rise  (hr_rise_unused),
      .fall  (hr_fall)
   );

   assign pix      = (state_q != IDLE) & pre_frame_vsync
                   & pre_frame_href & pre_frame_clken;
   assign wr_ok    = pix & (col_q != COL_MAX);
   assign win_ok   = wr_ok & (row_q >= ROW_TWO) & (col_q >= COL_TWO);
   assign line_end = (state_q != IDLE) & hr_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (vs_rise) state_d = FRAME;
         FRAME: begin
            if (vs_fall)             state_d = IDLE;
            else if (pre_frame_href) state_d = LINE;
         end
         LINE: begin
            if (vs_fall)      state_d = IDLE;
            else if (hr_fall) state_d = FRAME;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr   <= '0;
         ram_wr_en  <= '0;
         col_q      <= '0;
         row_q      <= '0;
         bank_q     <= '0;
         err_ovf    <= 1'b0;
         win_d1     <= 1'b0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= vs_fall;
         ram_wr_en  <= '0;
         win_d1     <= win_ok;
         win_valid  <= win_d1;
         if (vs_rise) begin
            col_q   <= '0;
            row_q   <= '0;
            bank_q  <= '0;
            err_ovf <= 1'b0;
         end else begin
            if (wr_ok) begin
               ram_wr_en <= 3'b001 << bank_q;
               ram_addr  <= col_q[ADDR_W-1:0];
               col_q     <= col_q + COL_ONE;
            end else if (pix) begin
               err_ovf <= 1'b1;
            end
            // Empty lines leave bank and row untouched
            if (line_end) begin
               col_q <= '0;
               if (col_q != '0) begin
                  bank_q <= next_bank(bank_q);
                  if (row_q != '1) row_q <= row_q + ROW_ONE;
               end
            end
         end
      end
   end

`ifdef VIP_LINEBUF_WIDTH_CHECK_EN
   logic [ADDR_W:0] width_q;
   logic            width_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q   <= '0;
         width_vld <= 1'b0;
         err_width <= 1'b0;
      end else if (vs_rise) begin
         width_vld <= 1'b0;
         err_width <= 1'b0;
      end else if (line_end && col_q != '0) begin
         if (!width_vld) begin
            width_q   <= col_q;
            width_vld <= 1'b1;
         end else if (col_q != width_q) begin
            err_width <= 1'b1;
         end
      end
   end
`else
   assign err_width = 1'b0;
`endif

   assign col_cnt  = col_q[ADDR_W-1:0];
   assign row_cnt  = row_q;
   assign row1_sel = next_bank(bank_q);
   assign row2_sel = next_bank(next_bank(bank_q));

endmodule

// File: tb/tb_vip_linebuf_ctrl.sv
// tb_vip_linebuf_ctrl: randomized and directed checks of vip_linebuf_ctrl
// against a pixel/line-count reference model.
module tb_vip_linebuf_ctrl;

   localparam int IMG  = 8;
   localparam int AW   = 4;
   localparam int RW   = 3;
   localparam int RMAX = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vs = 1'b0;
   logic          hr = 1'b0;
   logic          ck = 1'b0;
   logic [AW-1:0] ram_addr;
   logic [2:0]    ram_wr_en;
   logic [1:0]    row1_sel;
   logic [1:0]    row2_sel;
   logic [AW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic          win_valid;
   logic          frame_done;
   logic          err_ovf;
   logic          err_width;

   vip_linebuf_ctrl #(
      .IMG_W_MAX (IMG),
      .ADDR_W    (AW),
      .ROW_W     (RW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pre_frame_vsync (vs),
      .pre_frame_href  (hr),
      .pre_frame_clken (ck),
      .ram_addr        (ram_addr),
      .ram_wr_en       (ram_wr_en),
      .row1_sel        (row1_sel),
      .row2_sel        (row2_sel),
      .col_cnt         (col_cnt),
      .row_cnt         (row_cnt),
      .win_valid       (win_valid),
      .frame_done      (frame_done),
      .err_ovf         (err_ovf),
      .err_width       (err_width)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit            m_primed, m_pvs, m_phr, m_active, m_win_pipe;
   bit            m_ovf, m_werr;
   int            m_col, m_lines, m_wfirst;
   logic [2:0]    e_wr;
   logic [AW-1:0] e_addr;
   logic          e_win, e_done;

   typedef logic [21:0] vec_t;

   function automatic vec_t obs_vec();
      return {ram_wr_en, ram_addr, win_valid, frame_done, col_cnt,
              row_cnt, row1_sel, row2_sel, err_ovf, err_width};
   endfunction

   function automatic vec_t exp_vec();
      int rows;
      rows = (m_lines > RMAX) ? RMAX : m_lines;
      return {e_wr, e_addr, e_win, e_done, AW'(m_col), RW'(rows),
              2'((m_lines + 1) % 3), 2'((m_lines + 2) % 3), m_ovf, m_werr};
   endfunction

   task automatic model_reset();
      m_primed = 0; m_active = 0; m_win_pipe = 0;
      m_col = 0; m_lines = 0; m_ovf = 0; m_werr = 0; m_wfirst = -1;
      e_wr = '0; e_addr = '0; e_win = 0; e_done = 0;
   endtask

   // Drive one cycle; model works from pixel counts per line and
   // non-empty line counts per frame.
   task automatic step(input bit v, input bit h, input bit c);
      bit vr, vf, hf;
      vs = v; hr = h; ck = c;
      vr = m_primed && v && !m_pvs;
      vf = m_primed && !v && m_pvs;
      hf = m_primed && !h && m_phr;
      e_done = vf;
      e_wr = '0;
      e_win = m_win_pipe;
      m_win_pipe = 0;
      if (vr) begin
         m_active = 1; m_col = 0; m_lines = 0;
         m_ovf = 0; m_werr = 0; m_wfirst = -1;
      end else begin
         if (m_active && v && h && c) begin
            if (m_col < IMG) begin
               e_wr = 3'(1 << (m_lines % 3));
               e_addr = AW'(m_col);
               m_win_pipe = (m_lines >= 2) && (m_col >= 2);
               m_col++;
            end else begin
               m_ovf = 1;
            end
         end
         if (m_active && hf) begin
            if (m_col > 0) begin
`ifdef VIP_LINEBUF_WIDTH_CHECK_EN
               if (m_wfirst < 0) m_wfirst = m_col;
               else if (m_col != m_wfirst) m_werr = 1;
`endif
               m_lines++;
            end
            m_col = 0;
         end
         if (vf) m_active = 0;
      end
      m_pvs = v; m_phr = h; m_primed = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; vs = 0; hr = 0; ck = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset got %h want %h", obs_vec(), exp_vec());
      end
      n_cmp++;
      if (row1_sel !== 2'd1 || row2_sel !== 2'd2) begin
         n_bad++;
         $display("FAIL reset_sel got %0d/%0d want 1/2", row1_sel, row2_sel);
      end
      n_cmp++;
      rst_n = 1;
   endtask

   task automatic test_frame_4x4(input bit gaps);
      int wins = 0;
      int wrs = 0;
      step(0, 0, 0);
      step(1, 0, 0);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < (gaps ? 8 : 4) + 2; i++) begin
            if (i < (gaps ? 8 : 4)) step(1, 1, gaps ? !i[0] : 1'b1);
            else step(1, 0, 0);
            if (obs_vec() !== exp_vec()) begin
               n_bad++;
               $display("FAIL frame4 gaps=%0d r=%0d i=%0d got %h want %h",
                        gaps, r, i, obs_vec(), exp_vec());
            end
            n_cmp++;
            wins += int'(win_valid);
            wrs += int'(ram_wr_en != 3'b000);
         end
      end
      step(0, 0, 0);
      if (frame_done !== 1'b1) begin
         n_bad++;
         $display("FAIL frame4_done got %0b want 1", frame_done);
      end
      n_cmp++;
      if (wins != 4 || wrs != 16) begin
         n_bad++;
         $display("FAIL frame4_count gaps=%0d got win=%0d wr=%0d want 4/16",
                  gaps, wins, wrs);
      end
      n_cmp++;
   endtask

   task automatic test_overflow();
      int wrs = 0;
      step(0, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 1);
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL ovf i=%0d got %h want %h", i, obs_vec(), exp_vec());
         end
         n_cmp++;
         wrs += int'(ram_wr_en != 3'b000);
      end
      if (col_cnt !== 4'd8 || err_ovf !== 1'b1 || wrs != 8) begin
         n_bad++;
         $display("FAIL ovf_hold got col=%0d ovf=%0b wr=%0d want 8/1/8",
                  col_cnt, err_ovf, wrs);
      end
      n_cmp++;
      step(1, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      if (err_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear got %0b want 0", err_ovf);
      end
      n_cmp++;
   endtask

   task automatic test_width();
      int widths[3] = '{6, 6, 5};
      logic exp_w;
`ifdef VIP_LINEBUF_WIDTH_CHECK_EN
      exp_w = 1'b1;
`else
      exp_w = 1'b0;
`endif
      step(0, 0, 0);
      step(1, 0, 0);
      for (int l = 0; l < 3; l++) begin
         for (int p = 0; p < widths[l]; p++) step(1, 1, 1);
         step(1, 0, 0);
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL width l=%0d got %h want %h", l, obs_vec(), exp_vec());
         end
         n_cmp++;
         if (err_width !== (l == 2 ? exp_w : 1'b0)) begin
            n_bad++;
            $display("FAIL width_err l=%0d got %0b want %0b",
                     l, err_width, l == 2 ? exp_w : 1'b0);
         end
         n_cmp++;
      end
      step(0, 0, 0);
   endtask

   task automatic test_restart();
      int wins = 0;
      step(0, 0, 0);
      step(1, 0, 0);
      for (int r = 0; r < 3; r++) begin
         repeat (4) step(1, 1, 1);
         step(1, 0, 0);
      end
      step(1, 1, 1);
      step(1, 1, 1);
      step(0, 1, 1);
      step(1, 1, 1);
      if (row_cnt !== 3'd0 || row1_sel !== 2'd1 || row2_sel !== 2'd2 ||
          col_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL restart got row=%0d sel=%0d/%0d col=%0d want 0 1/2 0",
                  row_cnt, row1_sel, row2_sel, col_cnt);
      end
      n_cmp++;
      for (int i = 0; i < 16; i++) begin
         case (i)
            0, 1:    step(1, 1, 1);
            2, 7, 12, 13: step(1, 0, 0);
            default: step(1, 1, 1);
         endcase
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL restart i=%0d got %h want %h", i, obs_vec(), exp_vec());
         end
         n_cmp++;
         wins += int'(win_valid);
      end
      if (wins != 2) begin
         n_bad++;
         $display("FAIL restart_win got %0d want 2", wins);
      end
      n_cmp++;
      step(0, 0, 0);
   endtask

   task automatic test_reset_midline();
      int wrs = 0;
      int dones = 0;
      step(0, 0, 0);
      step(1, 0, 0);
      for (int r = 0; r < 2; r++) begin
         repeat (4) step(1, 1, 1);
         step(1, 0, 0);
      end
      step(1, 1, 1);
      step(1, 1, 1);
      vs = 1; hr = 1; ck = 1;
      #2 rst_n = 0;
      model_reset();
      #1;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL rst_async got %h want %h", obs_vec(), exp_vec());
      end
      n_cmp++;
      @(posedge clk);
      #1;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL rst_next got %h want %h", obs_vec(), exp_vec());
      end
      n_cmp++;
      rst_n = 1;
      for (int i = 0; i < 15; i++) begin
         step(1, (i % 5) != 4, 1);
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rst_idle i=%0d got %h want %h", i, obs_vec(), exp_vec());
         end
         n_cmp++;
         wrs += int'(ram_wr_en != 3'b000);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         dones += int'(frame_done);
      end
      if (wrs != 0 || dones != 1) begin
         n_bad++;
         $display("FAIL rst_resume got wr=%0d done=%0d want 0/1", wrs, dones);
      end
      n_cmp++;
   endtask

   task automatic test_random();
      int nl, w, sent;
      bit c;
      for (int f = 0; f < 6; f++) begin
         step(0, 0, 0);
         step(1, 0, 0);
         nl = $urandom_range(2, 10);
         for (int l = 0; l < nl; l++) begin
            w = $urandom_range(0, 10);
            sent = 0;
            if (w == 0) step(1, 1, 0);
            while (sent < w) begin
               c = ($urandom_range(0, 3) != 0);
               step(1, 1, c);
               if (obs_vec() !== exp_vec()) begin
                  n_bad++;
                  $display("FAIL rand f=%0d l=%0d got %h want %h",
                           f, l, obs_vec(), exp_vec());
               end
               n_cmp++;
               if (c) sent++;
            end
            if (l == nl - 1 && $urandom_range(0, 1) == 1) step(0, 0, 0);
            else step(1, 0, 0);
            if (obs_vec() !== exp_vec()) begin
               n_bad++;
               $display("FAIL rand_end f=%0d l=%0d got %h want %h",
                        f, l, obs_vec(), exp_vec());
            end
            n_cmp++;
         end
         step(0, 0, 0);
         step(0, 0, 0);
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rand_frame f=%0d got %h want %h",
                     f, obs_vec(), exp_vec());
         end
         n_cmp++;
      end
   endtask

   initial begin
      test_reset();
      test_frame_4x4(1'b0);
      test_frame_4x4(1'b1);
      test_overflow();
      test_width();
      test_restart();
      test_reset_midline();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vip_linebuf_ctrl.md
# vip_linebuf_ctrl

Sequencing controller for the 3x3 window path of the VIP pipeline. It tracks pixel column and row position from the frame sync signals and generates the address and one-hot write enables for a three-bank line buffer. It also drives the read-bank selects for the two older rows, a window-valid flag aligned with the 3x3 matrix output, and frame status. It sits beside the matrix generator and replaces the free-running shift-RAM taps with explicit, bounded addressing.

## Interface
- IMG_W_MAX, 1024, maximum pixels per line; one line-buffer bank depth
- ADDR_W, 10, line-buffer address width; must satisfy 2^ADDR_W >= IMG_W_MAX
- ROW_W, 11, row counter width
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pre_frame_vsync  in  1  frame active, high
- pre_frame_href  in  1  line active, high
- pre_frame_clken  in  1  pixel strobe; valid only while href is high
- ram_addr  out  ADDR_W  write/read column address, registered
- ram_wr_en  out  3  one-hot bank write enable, registered
- row1_sel  out  2  bank index of the oldest row (p1x)
- row2_sel  out  2  bank index of the middle row (p2x)
- col_cnt  out  ADDR_W  column of the current pixel
- row_cnt  out  ROW_W  row of the current line, saturating
- win_valid  out  1  3x3 window fully inside the image, aligned with matrix output
- frame_done  out  1  one-cycle pulse at vsync falling edge
- err_ovf  out  1  sticky: line longer than IMG_W_MAX
- err_width  out  1  sticky: line width mismatch (see Configuration)

## Operation
- FSM states and transitions:
  - IDLE → FRAME on vsync rising edge.
  - FRAME → LINE on href high.
  - LINE → FRAME on href falling edge.
  - Any state → IDLE on vsync falling edge; this also pulses frame_done.
- vsync rising edge, in any state including mid-frame, restarts the frame:
  - row_cnt=0, col_cnt=0, wr_bank=0
  - err_ovf and err_width cleared
- In IDLE, href and clken are ignored: no writes, win_valid=0.
- In LINE, each clken writes bank wr_bank at address col_cnt, then col_cnt increments.
- Overflow: a clken with col_cnt==IMG_W_MAX suppresses the write, holds col_cnt and sets err_ovf.
- Line end (href falling edge):
  - If the line had ≥1 pixel: wr_bank advances 0→1→2→0 and row_cnt increments, saturating at 2^ROW_W-1.
  - A line with zero pixels changes nothing.
  - col_cnt returns to 0 in all cases.
- Read-bank selects: row2_sel = (wr_bank+2) mod 3 and row1_sel = (wr_bank+1) mod 3. Both update on the same cycle as wr_bank.
- win_valid for a pixel requires row_cnt≥2 and col_cnt≥2, evaluated before the increment. The window is centred at (row-1, col-1). Edge rows and columns never assert win_valid.
- All arithmetic is unsigned. The bank index is never 3.

## Timing
- Reset values: all outputs 0, FSM in IDLE, wr_bank=0, row1_sel=1, row2_sel=2.
- Pixel accepted at cycle N (clken high) gives:
  - ram_wr_en and ram_addr at N+1 (one-cycle write pulse), matching the pixel data delayed by one register
  - win_valid at N+2, matching matrix output latency
- Edge detection uses inputs registered one cycle:
  - frame_done is high at cycle E+1 for a vsync falling edge at cycle E.
  - wr_bank and the read selects change at E+1 for an href falling edge at cycle E.
- clken low inside a line: no write, counters hold, win_valid=0 for that slot.
- Simultaneous href falling edge and vsync falling edge: the line-end update occurs, then IDLE.
- Reset asserted mid-line: all state clears immediately; the frame resumes only on the next vsync rising edge.

## Configuration
- VIP_LINEBUF_WIDTH_CHECK_EN
  - Defined:
    - The first non-empty line's width after a vsync rising edge is latched.
    - Each later non-empty line whose final col_cnt differs sets err_width, sticky until the next vsync rising edge.
  - Undefined: err_width tied 0, and no width register is built.

## Structure
- Shared package vip_pkg holds:
  - the FSM state enum (IDLE, FRAME, LINE)
  - the bank-index type and NUM_BANKS=3
  - a next-bank mod-3 function
- Sub-module vip_sync_edge: registers vsync and href, emits rise and fall pulses; one instance per signal.

## Test plan
- 4x4 frame, continuous clken:
  - ram_addr runs 0,1,2,3 per line.
  - ram_wr_en follows 001, 010, 100, 001.
  - Exactly 4 win_valid pulses, all at N+2.
- 4x4 frame with clken low on alternate cycles: same addresses and 4 win_valid pulses; no write on gap cycles.
- IMG_W_MAX=8, 10-pixel line:
  - addresses 0..7 written
  - err_ovf=1 from the 9th pixel
  - col_cnt holds 8; err_ovf cleared by the next vsync rising edge
- VIP_LINEBUF_WIDTH_CHECK_EN defined, line widths 6, 6, 5:
  - err_width rises one cycle after the third href falling edge.
  - Undefined build: err_width stays 0.
- vsync rising edge mid-line at row 3: row_cnt=0, wr_bank=0, row1_sel=1, row2_sel=2 at the next cycle; no win_valid until row 2.
- rst_n low during pixel 2 of row 2: all outputs 0 next cycle; href ignored until vsync rises; frame_done pulses once at the vsync falling edge.
